segm_scanner: RTL
=================

# segm_scanner

Time-multiplexed driver for the four-digit, common-anode 7-segment display on the board. It sits directly downstream of the segment-pattern generator and consumes its four active-low 7-bit digit patterns. It scans one digit at a time, with a blanking gap between digits and a 4-level brightness control. All four patterns are snapshotted at each frame boundary so that a single frame never mixes old and new content.

## Interface
- `SLOT_TICKS`, 16: scan ticks per digit slot (drive plus blank). Legal range 9..256.
- `BLANK_TICKS`, 2: ticks of the slot during which every anode is off (anti-ghosting). Minimum 1.
- `SLOT_TICKS - BLANK_TICKS` is called DRIVE_TICKS and must be ≥ 8.
- `sysclk`  in  1  system clock; all state is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `scan_tick`  in  1  single-cycle enable pulse from the shared prescaler; all counters advance only on cycles where it is high.
- `digit0`..`digit3`  in  7 each  active-low segment patterns (bit=0 means segment lit). `7'h7F` means blank.
- `bright`  in  2  brightness level, 0 = dimmest, 3 = full.
- `seg_n`  out  7  active-low segment bus, registered.
- `dig_n`  out  4  active-low anode enables, registered. Bit i selects digit i.
- `frame_start`  out  1  one-`sysclk` pulse marking the first lit cycle of digit 0.

## Operation
- State: FSM {DRIVE, BLANK}, 2-bit digit index `idx`, 8-bit tick counter `cnt`, four 7-bit shadow registers, 2-bit `bright_q`.
- Reset values: state=BLANK, idx=3, cnt=0, shadows=`7'h7F`, bright_q=3, seg_n=`7'h7F`, dig_n=`4'hF`, frame_start=0.
- All transitions below occur only on cycles where `scan_tick` is high. Without ticks, every register holds.
- DRIVE:
  - If cnt == DRIVE_TICKS-1: cnt←0 and state←BLANK.
  - Otherwise cnt←cnt+1.
- BLANK:
  - If cnt == BLANK_TICKS-1: cnt←0, state←DRIVE, idx←idx+1 (3 wraps to 0).
  - Otherwise cnt←cnt+1.
- Frame boundary is the BLANK→DRIVE transition where the new idx is 0. On that same edge:
  - shadow[i]←digit i for all four digits;
  - bright_q←bright;
  - frame_start is set for exactly one cycle.
- `digit*` and `bright` changes made at any other time are ignored until the next frame boundary.
- on_ticks = DRIVE_TICKS >> (3 - bright_q). With defaults: 1, 3, 7, 14 for bright 0..3.
- lit = (state==DRIVE) && (cnt < on_ticks).
- Output registers (next-state is computed from the registered state/cnt/idx):
  - seg_n←lit ? shadow[idx] : `7'h7F`.
  - dig_n←lit ? ~(4'b0001 << idx) : `4'hF`.
- Invariant: at most one `dig_n` bit is low at any time, and `dig_n`=`4'hF` whenever `seg_n`=`7'h7F` due to blanking.
- Segment bit order passes through unchanged from input to `seg_n`.

## Timing
- Output latency: `seg_n`/`dig_n` reflect FSM state one `sysclk` after that state is registered. Net latency is 2 cycles from the qualifying `scan_tick`.
- `frame_start` is asserted in the same cycle `dig_n` first shows `4'b1110`.
- Frame length: 4×SLOT_TICKS scan ticks (64 with defaults).
- After reset release, the first BLANK_TICKS ticks are blank. The first frame boundary then snapshots the inputs.
- When `scan_tick` is tied high, one tick occurs per `sysclk`:
  - digit 0 lit for on_ticks cycles;
  - dark for (SLOT_TICKS - on_ticks) cycles;
  - then digit 1, and so on.
- Reset asserted mid-frame: every output goes immediately (asynchronously) to its reset value. The frame restarts as after power-up, and no partial digit is driven.
- `scan_tick` held low indefinitely: outputs freeze in their current values. A lit digit stays lit; this is the caller's responsibility.

## Test plan
- Reset: assert `reset_n`=0 at arbitrary times.
  - Required: `seg_n`=`7'h7F`, `dig_n`=`4'hF` and `frame_start`=0 within the same cycle (asynchronous).
  - After release with ticks every cycle: exactly 2 dark cycles, then `frame_start` pulses once.
- Scan order: `scan_tick`=1 continuously, bright=3, digit0..3 = `7'h47`, `7'h40`, `7'h08`, `7'h21`.
  - Required sequence: `dig_n` = 1110/`seg_n`=`47` for 14 cycles, 2 dark cycles, 1101/`40` ×14, 2 dark, 1011/`08` ×14, 2 dark, 0111/`21` ×14, 2 dark, then repeat.
  - `frame_start` every 64 cycles.
- Anti-tearing: change digit1 to `7'h4E` while digit 0 is lit.
  - Required: the current frame still shows `40` on digit 1.
  - The next frame shows `4E`.
- Brightness: bright=0, then 1, then 2.
  - Required lit cycles per slot: 1, 3, 7.
  - A new level takes effect only at the next `frame_start`. A change mid-frame does not alter the current frame.
- Sparse ticks: `scan_tick` pulsed once every 5 cycles.
  - Required: slot length is 80 cycles, and outputs are stable between ticks.
  - Never more than one `dig_n` bit low; `dig_n`=`4'hF` throughout BLANK.
- Reset mid-operation: assert reset while digit 2 is lit, release after 3 cycles.
  - Required: immediate blank.
  - The next lit digit is digit 0, showing freshly sampled inputs.

Source files
------------

// File: rtl/segm_scanner.sv
// segm_scanner: time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Scans one digit per slot (drive phase then blanking phase), applies a 4-level
// brightness by shortening the lit portion of the drive phase, and snapshots all
// digit patterns plus the brightness level at each frame boundary.
module segm_scanner #(
  parameter int unsigned SLOT_TICKS  = 16,
  parameter int unsigned BLANK_TICKS = 2
) (
  input  logic       sysclk,
  input  logic       reset_n,
  input  logic       scan_tick,
  input  logic [6:0] digit0,
  input  logic [6:0] digit1,
  input  logic [6:0] digit2,
  input  logic [6:0] digit3,
  input  logic [1:0] bright,
  output logic [6:0] seg_n,
  output logic [3:0] dig_n,
  output logic       frame_start
);

  localparam int unsigned DRIVE_TICKS = SLOT_TICKS - BLANK_TICKS;
  localparam logic [7:0] DriveLast    = 8'(DRIVE_TICKS - 1);
  localparam logic [7:0] BlankLast    = 8'(BLANK_TICKS - 1);
  localparam logic [7:0] DriveTicks   = 8'(DRIVE_TICKS);

  typedef enum logic {
    StDrive = 1'b0,
    StBlank = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [3:0][6:0] shadow_q;
  logic [1:0]      bright_q;
  logic            boundary;
  logic            boundary_q;
  logic [7:0]      on_ticks;
  logic            lit;
  logic [6:0]      seg_d;
  logic [3:0]      dig_d;

  // Slot sequencing: advance counter / phase / digit index on scan ticks only.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    boundary = 1'b0;
    if (scan_tick) begin
      unique case (state_q)
        StDrive: begin
          if (cnt_q == DriveLast) begin
            cnt_d   = 8'd0;
            state_d = StBlank;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StBlank: begin
          if (cnt_q == BlankLast) begin
            cnt_d    = 8'd0;
            state_d  = StDrive;
            idx_d    = idx_q + 2'd1;
            // Entering digit 0 starts a new frame.
            boundary = (idx_q == 2'd3);
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = StBlank;
        end
      endcase
    end
  end

  // FSM state, index and tick counter registers.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StBlank;
      idx_q   <= 2'd3;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Frame snapshot of digit patterns and brightness so a frame never tears.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= {4{7'h7F}};
      bright_q <= 2'd3;
    end else if (boundary) begin
      shadow_q <= {digit3, digit2, digit1, digit0};
      bright_q <= bright;
    end
  end

  // Output decode from the registered scan position.
  always_comb begin
    on_ticks = DriveTicks >> (2'd3 - bright_q);
    lit      = (state_q == StDrive) && (cnt_q < on_ticks);
    seg_d    = 7'h7F;
    dig_d    = 4'hF;
    if (lit) begin
      seg_d = shadow_q[idx_q];
      dig_d = ~(4'b0001 << idx_q);
    end
  end

  // Registered outputs; frame_start is delayed one cycle so it lines up with
  // the first cycle that digit 0 is actually driven.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      seg_n       <= 7'h7F;
      dig_n       <= 4'hF;
      boundary_q  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      seg_n       <= seg_d;
      dig_n       <= dig_d;
      boundary_q  <= boundary;
      frame_start <= boundary_q;
    end
  end

endmodule
